// File: rtl/vpi_arb_pkg.sv
// Shared widths, TID layout and state encoding for the DP->VPI request arbiter.
// Optional error checking in the top is enabled by defining VPI_ARB_ERR_CHECK_EN.
package vpi_arb_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int ADDR_WIDTH      = 31;
   localparam int REQ_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int TID_WIDTH       = 16;
   localparam int NUM_REQ         = 4;
   localparam int MAX_OUTSTANDING = 7;
   localparam int DP_DATA_WIDTH   = TID_WIDTH + REQ_WIDTH;
   localparam int VPI_DATA_WIDTH  = TID_WIDTH + DATA_WIDTH;
   localparam int SEQ_W           = 8;
   localparam int IDX_W           = $clog2(NUM_REQ);
   localparam int CNT_W           = SEQ_W;
   localparam int SUM_W           = CNT_W + IDX_W;

   localparam logic [1:0] ERR_ORPHAN = 2'd1;
   localparam logic [1:0] ERR_SEQ    = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } arb_state_t;

   typedef logic [IDX_W-1:0]     idx_t;
   typedef logic [SEQ_W-1:0]     seq_t;
   typedef logic [TID_WIDTH-1:0] tid_t;

   // TID = {zero pad, idx, seq}
   function automatic tid_t tid_pack(input idx_t idx, input seq_t seq);
      tid_t t;
      t = '0;
      t[SEQ_W +: IDX_W] = idx;
      t[SEQ_W-1:0]      = seq;
      return t;
   endfunction

   function automatic idx_t tid_idx(input tid_t t);
      return t[SEQ_W +: IDX_W];
   endfunction

   function automatic seq_t tid_seq(input tid_t t);
      return t[SEQ_W-1:0];
   endfunction

endpackage

// File: rtl/vpi_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arbiter
   import vpi_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  idx_t               ptr,
   output logic [NUM_REQ-1:0] grant,
   output idx_t               grant_idx,
   output logic               grant_any
);

   idx_t cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      // NUM_REQ is a power of two, so idx_t addition wraps naturally
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ptr + idx_t'(k);
         if (!grant_any && eligible[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/vpi_req_arbiter.sv
// Shares the DP->VPI FIFO pair between NUM_REQ requesters: tags/issues requests, routes responses by TID.
// Define VPI_ARB_ERR_CHECK_EN to add orphan / out-of-order response detection (err_flag, err_code).
module vpi_req_arbiter
   import vpi_arb_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*REQ_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [DATA_WIDTH-1:0]        resp_data,
   output logic [TID_WIDTH-1:0]         resp_tid,
   output logic [DP_DATA_WIDTH-1:0]     A_data_in,
   output logic                         A_wr_ctr,
   input  logic                         A_full,
   input  logic [VPI_DATA_WIDTH-1:0]    B_data_out,
   output logic                         B_rd_ctr,
   input  logic                         B_empty,
   input  logic                         drain_req,
   output logic                         drain_done,
   output logic [7:0]                   outstanding_total
`ifdef VPI_ARB_ERR_CHECK_EN
   ,
   output logic                         err_flag,
   output logic [1:0]                   err_code
`endif
);

   // state | meaning
   // RUN   | issuing requests, serving responses
   // DRAIN | no issue, responses continue until nothing is outstanding
   // HALT  | drained, drain_done high, waits for drain_req to drop

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam seq_t             SEQ_ONE = SEQ_W'(1);
   localparam idx_t             IDX_ONE = IDX_W'(1);

   arb_state_t          state, state_nxt;
   idx_t                rr_ptr;
   seq_t                seq_cnt         [NUM_REQ];
   logic [CNT_W-1:0]    outstanding     [NUM_REQ];
   logic [CNT_W-1:0]    outstanding_nxt [NUM_REQ];
   logic [SUM_W-1:0]    sum_nxt;
   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  grant;
   idx_t                grant_idx;
   logic                grant_any;
   logic                issue;
   logic                pop;
   logic                all_idle;
   tid_t                b_tid;
   idx_t                b_idx;

   always_comb begin
      eligible = '0;
      all_idle = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (outstanding[i] < CNT_MAX);
         if (outstanding[i] != '0) all_idle = 1'b0;
      end
   end

   rr_arbiter u_rr_arbiter (
      .eligible  (eligible),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign issue     = (state == ST_RUN) && !A_full && grant_any;
   assign req_ready = issue ? grant : '0;
   assign A_wr_ctr  = issue;
   assign A_data_in = issue ? {tid_pack(grant_idx, seq_cnt[grant_idx]),
                               req_data[int'(grant_idx)*REQ_WIDTH +: REQ_WIDTH]} : '0;

   assign pop      = !B_empty;
   assign B_rd_ctr = pop;
   assign b_tid    = B_data_out[VPI_DATA_WIDTH-1 -: TID_WIDTH];
   assign b_idx    = tid_idx(b_tid);

   // Saturating decrement first, then increment: a same-cycle issue+response nets to zero,
   // while a response to an idle requester (orphan) leaves the issue's +1 intact.
   always_comb begin
      sum_nxt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         outstanding_nxt[i] = outstanding[i];
         if (pop && (b_idx == idx_t'(i)) && (outstanding[i] != '0))
            outstanding_nxt[i] = outstanding[i] - CNT_ONE;
         if (issue && (grant_idx == idx_t'(i)))
            outstanding_nxt[i] = outstanding_nxt[i] + CNT_ONE;
         sum_nxt = sum_nxt + SUM_W'(outstanding_nxt[i]);
      end
   end

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         ST_RUN: begin
            if (drain_req) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req)    state_nxt = ST_RUN;
            else if (all_idle) state_nxt = ST_HALT;
         end
         ST_HALT: begin
            drain_done = 1'b1;
            if (!drain_req) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_RUN;
         rr_ptr            <= '0;
         resp_valid        <= '0;
         resp_data         <= '0;
         resp_tid          <= '0;
         outstanding_total <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            seq_cnt[i]     <= '0;
            outstanding[i] <= '0;
         end
      end else begin
         state      <= state_nxt;
         resp_valid <= '0;
         if (issue) begin
            rr_ptr             <= grant_idx + IDX_ONE;
            seq_cnt[grant_idx] <= seq_cnt[grant_idx] + SEQ_ONE;
         end
         if (pop) begin
            resp_valid[b_idx] <= 1'b1;
            resp_data         <= B_data_out[DATA_WIDTH-1:0];
            resp_tid          <= b_tid;
         end
         for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= outstanding_nxt[i];
         outstanding_total <= (sum_nxt > SUM_W'(255)) ? 8'hFF : sum_nxt[7:0];
      end
   end

`ifdef VPI_ARB_ERR_CHECK_EN
   seq_t exp_seq [NUM_REQ];
   logic orphan;
   logic misorder;

   assign orphan   = pop && (outstanding[b_idx] == '0);
   assign misorder = pop && !orphan && (tid_seq(b_tid) != exp_seq[b_idx]);

   // Only the first error is recorded; later ones are ignored until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag <= 1'b0;
         err_code <= 2'd0;
         for (int i = 0; i < NUM_REQ; i++) exp_seq[i] <= '0;
      end else begin
         if (pop && !orphan) exp_seq[b_idx] <= exp_seq[b_idx] + SEQ_ONE;
         if (!err_flag && (orphan || misorder)) begin
            err_flag <= 1'b1;
            err_code <= orphan ? ERR_ORPHAN : ERR_SEQ;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vpi_req_arbiter.sv
// Directed bench for vpi_req_arbiter: issue vector table plus hand sequences for limit, reset, drain.
module tb_vpi_req_arbiter;
   import vpi_arb_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*REQ_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           resp_valid;
   logic [DATA_WIDTH-1:0]        resp_data;
   logic [TID_WIDTH-1:0]         resp_tid;
   logic [DP_DATA_WIDTH-1:0]     A_data_in;
   logic                         A_wr_ctr;
   logic                         A_full;
   logic [VPI_DATA_WIDTH-1:0]    B_data_out;
   logic                         B_rd_ctr;
   logic                         B_empty;
   logic                         drain_req;
   logic                         drain_done;
   logic [7:0]                   outstanding_total;
`ifdef VPI_ARB_ERR_CHECK_EN
   logic                         err_flag;
   logic [1:0]                   err_code;
`endif

   int checks = 0;
   int errors = 0;

   vpi_req_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid         (req_valid),
      .req_data          (req_data),
      .req_ready         (req_ready),
      .resp_valid        (resp_valid),
      .resp_data         (resp_data),
      .resp_tid          (resp_tid),
      .A_data_in         (A_data_in),
      .A_wr_ctr          (A_wr_ctr),
      .A_full            (A_full),
      .B_data_out        (B_data_out),
      .B_rd_ctr          (B_rd_ctr),
      .B_empty           (B_empty),
      .drain_req         (drain_req),
      .drain_done        (drain_done),
      .outstanding_total (outstanding_total)
`ifdef VPI_ARB_ERR_CHECK_EN
      ,
      .err_flag          (err_flag),
      .err_code          (err_code)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic        full;
      logic [3:0]  exp_ready;
      int          exp_idx;
      logic [15:0] exp_tid;
      logic [7:0]  exp_total;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   function automatic logic [REQ_WIDTH-1:0] req_word(input int i);
      return {1'b1, ADDR_WIDTH'(32'h0A + i), DATA_WIDTH'(32'h7 + 16 * i)};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_issue(input string name, input logic [3:0] rdy, input int idx,
                               input logic [15:0] tid);
      chk({name, " req_ready"}, req_ready, rdy);
      chk({name, " A_wr_ctr"}, A_wr_ctr, 1'b1);
      chk({name, " A_data_in"}, A_data_in, {tid, req_word(idx)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      A_full     = 1'b0;
      B_empty    = 1'b1;
      B_data_out = '0;
      drain_req  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*REQ_WIDTH +: REQ_WIDTH] = req_word(i);

      //          rv      full  ready   idx tid       total
      vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 0, 16'h0000, 8'd1};
      vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1, 16'h0100, 8'd2};
      vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 2, 16'h0200, 8'd3};
      vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 3, 16'h0300, 8'd4};
      vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 0, 16'h0001, 8'd5};
      for (int k = 5; k < 10; k++)
         vecs[k] = '{4'b1111, 1'b1, 4'b0000, 0, 16'h0000, 8'd5};
      vecs[10] = '{4'b1111, 1'b0, 4'b0010, 1, 16'h0101, 8'd6};
      for (int k = 11; k < 17; k++)
         vecs[k] = '{4'b0100, 1'b0, 4'b0100, 2, 16'h0201 + 16'(k - 11), 8'(k - 4)};
      vecs[17] = '{4'b0100, 1'b0, 4'b0000, 0, 16'h0000, 8'd12};
      vecs[18] = '{4'b1111, 1'b0, 4'b1000, 3, 16'h0301, 8'd13};
      vecs[19] = '{4'b1111, 1'b0, 4'b0001, 0, 16'h0002, 8'd14};
      vecs[20] = '{4'b1111, 1'b0, 4'b0010, 1, 16'h0102, 8'd15};
      vecs[21] = '{4'b1111, 1'b0, 4'b1000, 3, 16'h0302, 8'd16};

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      chk("rst resp_valid", resp_valid, 4'b0000);
      chk("rst resp_data", resp_data, 32'h0);
      chk("rst resp_tid", resp_tid, 16'h0);
      chk("rst drain_done", drain_done, 1'b0);
      chk("rst total", outstanding_total, 8'd0);
      chk("rst A_wr_ctr", A_wr_ctr, 1'b0);
      chk("rst B_rd_ctr", B_rd_ctr, 1'b0);
`ifdef VPI_ARB_ERR_CHECK_EN
      chk("rst err_flag", err_flag, 1'b0);
`endif

      for (int k = 0; k < NV; k++) begin
         req_valid = vecs[k].rv;
         A_full    = vecs[k].full;
         #2;
         chk($sformatf("v%0d req_ready", k), req_ready, vecs[k].exp_ready);
         chk($sformatf("v%0d A_wr_ctr", k), A_wr_ctr, |vecs[k].exp_ready);
         if (vecs[k].exp_ready != 4'b0000)
            chk($sformatf("v%0d A_data_in", k), A_data_in, {vecs[k].exp_tid, req_word(vecs[k].exp_idx)});
         cycle();
         chk($sformatf("v%0d total", k), outstanding_total, vecs[k].exp_total);
      end
      A_full = 1'b0;

      // requester 2 sits at the limit; its response frees one slot
      req_valid  = 4'b0100;
      B_empty    = 1'b0;
      B_data_out = {16'h0200, 32'hDEADBEEF};
      #2;
      chk("lim B_rd_ctr", B_rd_ctr, 1'b1);
      chk("lim req_ready", req_ready, 4'b0000);
      cycle();
      chk("lim resp_valid", resp_valid, 4'b0100);
      chk("lim resp_data", resp_data, 32'hDEADBEEF);
      chk("lim resp_tid", resp_tid, 16'h0200);
      chk("lim total", outstanding_total, 8'd15);
      B_data_out = {16'h0000, 32'h00001234};
      #2;
      expect_issue("lim regrant", 4'b0100, 2, 16'h0207);
      cycle();
      chk("lim2 resp_valid", resp_valid, 4'b0001);
      chk("lim2 resp_data", resp_data, 32'h00001234);
      chk("lim2 total", outstanding_total, 8'd15);

      // asynchronous reset in the middle of traffic
      req_valid  = 4'b1111;
      B_data_out = {16'h0300, 32'h55555555};
      rst_n      = 1'b0;
      #1;
      chk("arst resp_valid", resp_valid, 4'b0000);
      chk("arst total", outstanding_total, 8'd0);
      chk("arst drain_done", drain_done, 1'b0);
      chk("arst resp_tid", resp_tid, 16'h0);
      cycle();
      req_valid = 4'b0000;
      B_empty   = 1'b1;
      rst_n     = 1'b1;
      cycle();

      // orphan: response for requester 1 with nothing in flight
      B_empty    = 1'b0;
      B_data_out = {16'h0105, 32'hCAFE0001};
      #2;
      chk("orph B_rd_ctr", B_rd_ctr, 1'b1);
      cycle();
      B_empty = 1'b1;
      chk("orph resp_valid", resp_valid, 4'b0010);
      chk("orph resp_tid", resp_tid, 16'h0105);
      chk("orph resp_data", resp_data, 32'hCAFE0001);
      chk("orph total", outstanding_total, 8'd0);
`ifdef VPI_ARB_ERR_CHECK_EN
      chk("orph err_flag", err_flag, 1'b1);
      chk("orph err_code", err_code, 2'd1);
`endif

      // three in flight, then drain
      req_valid = 4'b0111;
      #2;
      expect_issue("dr issue0", 4'b0001, 0, 16'h0000);
      cycle();
      #2;
      expect_issue("dr issue1", 4'b0010, 1, 16'h0100);
      cycle();
      #2;
      expect_issue("dr issue2", 4'b0100, 2, 16'h0200);
      cycle();
      chk("dr total3", outstanding_total, 8'd3);
      req_valid = 4'b0000;
      drain_req = 1'b1;
      cycle();
      req_valid = 4'b1111;
      for (int r = 0; r < 3; r++) begin
         B_empty    = 1'b0;
         B_data_out = {16'(r) << 8, 32'hA0 + 32'(r)};
         #2;
         chk($sformatf("dr%0d req_ready", r), req_ready, 4'b0000);
         chk($sformatf("dr%0d drain_done", r), drain_done, 1'b0);
         cycle();
         chk($sformatf("dr%0d resp_valid", r), resp_valid, 4'b0001 << r);
      end
      B_empty = 1'b1;
      chk("dr total0", outstanding_total, 8'd0);
      chk("dr done_lag", drain_done, 1'b0);
      #2;
      chk("dr last_ready", req_ready, 4'b0000);
      cycle();
      chk("dr done", drain_done, 1'b1);
      #2;
      chk("halt req_ready", req_ready, 4'b0000);
      cycle();
      chk("halt done_hold", drain_done, 1'b1);
      drain_req = 1'b0;
      #2;
      chk("halt exit_ready", req_ready, 4'b0000);
      cycle();
      chk("run done_low", drain_done, 1'b0);
      #2;
      expect_issue("run resume", 4'b1000, 3, 16'h0300);
      cycle();
      chk("run total", outstanding_total, 8'd1);
      req_valid = 4'b0000;

`ifdef VPI_ARB_ERR_CHECK_EN
      chk("dr err_code_held", err_code, 2'd1);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
      chk("seq err_clear", err_flag, 1'b0);
      cycle();
      req_valid = 4'b1000;
      #2;
      expect_issue("seq issue0", 4'b1000, 3, 16'h0300);
      cycle();
      #2;
      expect_issue("seq issue1", 4'b1000, 3, 16'h0301);
      cycle();
      req_valid  = 4'b0000;
      B_empty    = 1'b0;
      B_data_out = {16'h0301, 32'h0000BEEF};
      cycle();
      B_empty = 1'b1;
      chk("seq resp_valid", resp_valid, 4'b1000);
      chk("seq err_flag", err_flag, 1'b1);
      chk("seq err_code", err_code, 2'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vpi_req_arbiter.md
Name: vpi_req_arbiter

Overview:
- Shares the DP→VPI request FIFO pair (A: requests out, B: served data back) between NUM_REQ datapath requesters.
- Round-robin grants one requester per cycle, tags each request with a TID encoding source index and sequence number, and pushes {TID, request} into FIFO A.
- Pops served data from FIFO B and routes it back to the owning requester by TID.
- Provides a drain/halt sequence so the simulator interface can be finalised with no transactions in flight.

Parameters:
- DATA_WIDTH, 32, data field width
- ADDR_WIDTH, 31, address field width
- REQ_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH, request word {rw_flag, address, data}
- TID_WIDTH, 16, transaction ID width
- NUM_REQ, 4, number of requesters (power of 2, 2..16)
- MAX_OUTSTANDING, 7, per-requester in-flight limit (1..2^SEQ_W−1)
- DP_DATA_WIDTH, TID_WIDTH+REQ_WIDTH, FIFO A word
- VPI_DATA_WIDTH, TID_WIDTH+DATA_WIDTH, FIFO B word

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*REQ_WIDTH  flattened requests; requester i occupies [i*REQ_WIDTH +: REQ_WIDTH]
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- resp_valid  out  NUM_REQ  one-cycle response pulse, one-hot
- resp_data  out  DATA_WIDTH  served data
- resp_tid  out  TID_WIDTH  TID of served response
- A_data_in  out  DP_DATA_WIDTH  {TID, request} to FIFO A
- A_wr_ctr  out  1  FIFO A write enable
- A_full  in  1  FIFO A full
- B_data_out  in  VPI_DATA_WIDTH  {TID, data}; first-word-fall-through, valid while !B_empty
- B_rd_ctr  out  1  FIFO B pop
- B_empty  in  1  FIFO B empty
- drain_req  in  1  level: stop issuing and drain
- drain_done  out  1  level: halted, zero outstanding
- outstanding_total  out  8  sum of in-flight transactions

Behaviour:
- Reset: rr pointer=0; all sequence and outstanding counters=0; state=RUN; resp_valid=0; resp_data=0; resp_tid=0; drain_done=0.
- rst_n assertion mid-transaction drops all in-flight bookkeeping. Responses for pre-reset TIDs that arrive after reset are consumed and count as orphans.
- TID format: {zero pad, idx[IDX_W-1:0], seq[SEQ_W-1:0]}, with IDX_W=log2(NUM_REQ) and SEQ_W=8. idx occupies [SEQ_W +: IDX_W]. seq increments per issue of that requester, modulo 256.
- Eligible(i) = req_valid[i] & outstanding[i] < MAX_OUTSTANDING.
- Grant: first eligible index at or after the rr pointer, wrapping.
- Issue condition: state==RUN & !A_full & some requester eligible.
- Issue outputs, all combinational, zero latency: req_ready[g]=1; A_wr_ctr=1; A_data_in={TID(g), req_data[g]}.
- On the issue clock edge: rr pointer=g+1 mod NUM_REQ; seq[g]++; outstanding[g]++.
- When A_full=1, req_ready=0 and A_wr_ctr=0. The requester holds req_valid and req_data stable.
- Response path: B_rd_ctr = !B_empty (combinational, one pop per cycle). On the same edge:
  - resp_valid[idx]<=1, resp_data<=B_data_out[DATA_WIDTH-1:0], resp_tid<=TID field; one-cycle latency.
  - outstanding[idx]--.
- Issue and response for the same requester in one cycle: outstanding unchanged.
- Response for a requester with outstanding==0: counter saturates at 0. The response is still delivered and counts as an orphan.
- Requesters have no response backpressure; they must accept every resp_valid pulse.
- State machine:
  - RUN→DRAIN when drain_req=1.
  - DRAIN: no issue; responses continue. DRAIN→HALT when all outstanding==0.
  - HALT: drain_done=1, no issue. HALT→RUN when drain_req=0.
  - DRAIN with drain_req=0 → RUN.
- outstanding_total is the registered sum, saturating at 255.

Optional Feature:
- Macro VPI_ARB_ERR_CHECK_EN.
- Defined:
  - Adds output err_flag (1) and err_code (2). Code 1 = orphan response. Code 2 = out-of-order seq, i.e. seq ≠ expected next-response seq for that idx.
  - err_flag is sticky until reset; err_code holds the first error.
  - Adds per-requester expected-seq counters.
- Undefined: ports and counters absent; responses routed without checking.

Decomposition:
- Package vpi_arb_pkg: width parameters, SEQ_W, IDX_W, state encoding (RUN=0, DRAIN=1, HALT=2), TID pack/unpack functions.
- Sub-module rr_arbiter: NUM_REQ eligible vector plus pointer in, one-hot grant and index out, purely combinational.
- Counters and FSM stay in the top module.

Test Plan:
- Single requester 0 valid, req={1,0x0A,7}, A_full=0 → same cycle: A_wr_ctr=1, A_data_in TID=0x0000, then seq 1 next issue; outstanding_total=1.
- All 4 requesters valid continuously → grants 0,1,2,3,0… each cycle, TIDs 0x0000,0x0100,0x0200,0x0300,0x0001.
- Requester 2 reaches 7 outstanding, no responses → req_ready[2] stays 0, others still granted; push B word TID=0x0200 → next cycle resp_valid=4'b0100, requester 2 granted again.
- A_full=1 for 5 cycles with valids held → no A_wr_ctr, no req_ready, counters frozen; release → issue resumes at same rr pointer.
- 3 in flight, drain_req=1 → no issues; drain_done rises one cycle after third response; drain_req=0 → RUN, issue resumes.
- With VPI_ARB_ERR_CHECK_EN: B word TID=0x0105 with requester 1 idle → resp delivered, err_flag=1, err_code=1; rst_n low mid-burst → all counters 0, resp_valid=0, drain_done=0.
